// File: rtl/wb_port_arbiter_if.sv
// Bundle between the execute/memory stages and the register-file write port.
// The arbiter uses the master view; the upstream stages use the slave view.
interface wb_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
);
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_REGS    = 2 ** ADDRESS_WIDTH;

    logic                     alu_valid;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;

    logic                     ld_valid;
    logic                     ld_ready;
    logic [ADDRESS_WIDTH-1:0] ld_rd;
    logic [DATA_WIDTH-1:0]    ld_data;

    logic                     issue_valid;
    logic [ADDRESS_WIDTH-1:0] issue_rd;

    logic [ADDRESS_WIDTH-1:0] ad3;
    logic                     we3;
    logic [DATA_WIDTH-1:0]    wd3;
    logic [NUM_REGS-1:0]      pending;
    logic [COUNT_WIDTH-1:0]   fifo_count;

    modport master (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd,
        output ld_ready,
        output ad3, we3, wd3,
        output pending, fifo_count
    );

    modport slave (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd,
        input  ld_ready,
        input  ad3, we3, wd3,
        input  pending, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by ALU results (priority) and buffered
// load results, plus a pending-load scoreboard for RAW stalls in decode.
module wb_port_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.master bus
);
    localparam int PTR_WIDTH   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_REGS    = 2 ** ADDRESS_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT = COUNT_WIDTH'(FIFO_DEPTH);

    logic [ADDRESS_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr;
    logic [PTR_WIDTH-1:0]     rd_ptr;
    logic [COUNT_WIDTH-1:0]   count;

    logic [ADDRESS_WIDTH-1:0] ad3_q;
    logic                     we3_q;
    logic [DATA_WIDTH-1:0]    wd3_q;
    logic [NUM_REGS-1:0]      pending_q;
    logic [NUM_REGS-1:0]      pending_next;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     ld_fire;
    logic                     push;
    logic                     pop;
    logic                     alu_write;
    logic [ADDRESS_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0]    head_data;

    // Full/empty come from the count alone; pointers just wrap.
    assign fifo_full  = (count == DEPTH_COUNT);
    assign fifo_empty = (count == '0);
    assign ld_fire    = bus.ld_valid && !fifo_full;
    assign push       = ld_fire && (bus.ld_rd != '0);
    assign alu_write  = bus.alu_valid && (bus.alu_rd != '0);
    assign pop        = !bus.alu_valid && !fifo_empty;
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    assign bus.ld_ready   = !fifo_full;
    assign bus.ad3        = ad3_q;
    assign bus.we3        = we3_q;
    assign bus.wd3        = wd3_q;
    assign bus.pending    = pending_q;
    assign bus.fifo_count = count;

    // A new issue to the same register overrides the clear from a retiring load.
    always_comb begin
        pending_next = pending_q;
        if (pop) begin
            pending_next[head_rd] = 1'b0;
        end
        if (bus.issue_valid) begin
            pending_next[bus.issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.ld_rd;
            fifo_data[wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            we3_q     <= 1'b0;
            ad3_q     <= '0;
            wd3_q     <= '0;
            pending_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            if (push && !pop) begin
                count <= count + COUNT_WIDTH'(1);
            end else if (!push && pop) begin
                count <= count - COUNT_WIDTH'(1);
            end

            // ALU owns the port whenever alu_valid is high, even for rd==0.
            we3_q <= alu_write || pop;
            if (alu_write) begin
                ad3_q <= bus.alu_rd;
                wd3_q <= bus.alu_data;
            end else if (pop) begin
                ad3_q <= head_rd;
                wd3_q <= head_data;
            end
            pending_q <= pending_next;
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Writeback-side master for the CPU register file's single write port (ad3/we3/wd3).
- Merges single-cycle ALU results with multi-cycle load results from the data-memory path. Load results are buffered in a small FIFO.
- Tracks outstanding load destinations in a pending scoreboard so decode can stall on RAW hazards.
- Sits between execute/memory stages and the register file; the register file itself is unchanged.

Parameters:
ADDRESS_WIDTH, 5, register index width
DATA_WIDTH, 32, register data width
FIFO_DEPTH, 4, load-result buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle (no backpressure; must be accepted)
alu_rd  in  ADDRESS_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted when ld_valid && ld_ready
ld_rd  in  ADDRESS_WIDTH  load destination register
ld_data  in  DATA_WIDTH  load data
issue_valid  in  1  a load is issued this cycle; mark issue_rd pending
issue_rd  in  ADDRESS_WIDTH  destination of issued load
ad3  out  ADDRESS_WIDTH  register file write address (registered)
we3  out  1  register file write enable (registered)
wd3  out  DATA_WIDTH  register file write data (registered)
pending  out  2**ADDRESS_WIDTH  bit r set = load to register r outstanding
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently buffered

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (`rst`=1 at an edge): we3=0, ad3=0, wd3=0, pending=0, FIFO emptied, fifo_count=0.
  - Reset mid-operation discards all buffered entries and pending bits; no write is emitted in the following cycle.
- ld_ready = (fifo_count < FIFO_DEPTH), combinational from count only. It never depends on ld_valid.
- Enqueue on ld_valid && ld_ready.
  - Entry with ld_rd==0: the handshake completes, nothing is stored, count unchanged.
- Write-port selection each cycle, fixed priority:
  - ALU first: if alu_valid && alu_rd!=0, then next cycle we3=1, ad3=alu_rd, wd3=alu_data. FIFO does not pop.
  - alu_valid with alu_rd==0 is discarded. It still occupies the port: no FIFO pop that cycle.
  - Otherwise, if the FIFO is non-empty: pop head; next cycle we3=1, ad3/wd3 = head rd/data.
  - Otherwise: next cycle we3=0. ad3/wd3 hold previous values.
- Latency:
  - ALU result appears on the write port 1 cycle after alu_valid.
  - A load accepted into an empty FIFO with no ALU traffic appears 2 cycles after the handshake: enqueue edge, then pop edge. There is no bypass.
- Simultaneous push and pop: count unchanged; pushed entry goes to the tail.
- Full: ld_ready=0. A pop that cycle does not enable a same-cycle push.
- Order: loads are written in acceptance order. No ordering is enforced between ALU and load writes to the same rd; the issue stage must prevent that by stalling on pending.
- Starvation: continuous alu_valid blocks FIFO drain indefinitely. Backpressure appears via ld_ready=0.
- Pointers: the FIFO uses wrapping read/write pointers plus a separate count. The full/empty decision comes from count only.
- Scoreboard:
  - pending[r] sets on issue_valid && issue_rd==r && r!=0.
  - pending[r] clears at the edge where a FIFO pop to rd==r is registered into the write-port flops, i.e. the same edge we3 rises for it.
  - Set and clear of the same r in the same cycle: set wins.
  - ALU writes never clear pending.
  - pending[0] is always 0.
- Widths: ld_data/alu_data pass through unmodified. No sign extension happens here.

Test Plan:
- Reset, then idle 3 cycles -> we3=0, ad3=0, wd3=0, pending=0, fifo_count=0, ld_ready=1.
- alu_valid=1, alu_rd=5, alu_data=0x0000_00AA for 1 cycle -> next cycle we3=1, ad3=5, wd3=0xAA. Following cycle we3=0.
- issue_valid, issue_rd=10 -> pending[10]=1. Later ld handshake rd=10, data=0x1234_5678 with no ALU traffic -> 2 cycles later we3=1, ad3=10, wd3=0x12345678 and pending[10]=0 at that same edge.
- Hold alu_valid=1 (rd=1..8) while offering 5 loads -> ld_ready drops after 4 accepts, fifo_count=4. Release ALU -> 4 load writes in acceptance order, one per cycle; 5th load accepted when space frees.
- alu_rd=0 and ld_rd=0 traffic -> we3 never asserts for them; load handshake completes, fifo_count stays 0.
- Fill FIFO to 3, assert rst for 1 cycle -> fifo_count=0, pending=0, no write emitted in the following cycle.
